// File: rtl/mem_access_pkg.sv
// mem_access_pkg: load/store funct3 codes, stage states and the alignment rule.
package mem_access_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {MEM_IDLE = 1'b0, MEM_BUSY = 1'b1} state_e;

  // Unsupported funct3 codes fall through to "not aligned" so they are dropped.
  function automatic logic aligned(input logic [2:0] f3, input logic [1:0] a);
    return (f3 == F3_B) || (f3 == F3_BU) ||
           (((f3 == F3_H) || (f3 == F3_HU)) && !a[0]) ||
           ((f3 == F3_W) && (a == 2'b00));
  endfunction
endpackage

// File: rtl/mem_access_load_ext.sv
// load_ext: selects the addressed lane of a read word and sign/zero-extends it.
module load_ext
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = rdata[{addr, 3'b000} +: 8];
  assign h = addr[1] ? rdata[31:16] : rdata[15:0];
  always_comb
    data = (funct3 == F3_B)  ? {{24{b[7]}}, b} :
           (funct3 == F3_BU) ? {24'b0, b} :
           (funct3 == F3_H)  ? {{16{h[15]}}, h} :
           (funct3 == F3_HU) ? {16'b0, h} : rdata;
endmodule

// File: rtl/mem_access.sv
// mem_access: memory stage with single-outstanding req/ack bus, ack timeout and load alignment.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic        wmem_en_i,
  input  logic        rmem_en_i,
  input  logic [31:0] mem_addr_i,
  input  logic [2:0]  funct3_i,
  input  logic        wreg_en_i,
  input  logic [4:0]  wreg_addr_i,
  input  logic [31:0] wreg_data_i,
  output logic        stall_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_wstrb_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        wb_valid_o,
  output logic        wreg_en_o,
  output logic [4:0]  wreg_addr_o,
  output logic [31:0] wreg_data_o,
  output logic        misalign_o,
  output logic        bus_err_o
);
  state_e      state, state_n;
  logic [7:0]  cnt;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        wen_q;
  logic [4:0]  wa_q;
  logic        mem_en, ok, idle_in, accept, ack, tout;
  logic [3:0]  strb;
  logic [31:0] wdat, ext;

  assign mem_en  = wmem_en_i | rmem_en_i;
  assign ok      = aligned(funct3_i, mem_addr_i[1:0]);
  assign idle_in = (state == MEM_IDLE) && valid_i;
  assign accept  = idle_in && mem_en && ok;
  assign ack     = (state == MEM_BUSY) && bus_ack_i;
  // An ack arriving in the last allowed cycle wins over the timeout.
  assign tout    = (state == MEM_BUSY) && !bus_ack_i && (cnt == 8'(ACK_TIMEOUT - 1));
  assign strb    = (funct3_i[1:0] == 2'b00) ? 4'b0001 << mem_addr_i[1:0] :
                   (funct3_i[1:0] == 2'b01) ? 4'b0011 << mem_addr_i[1:0] : 4'b1111;
  assign wdat    = (funct3_i[1:0] == 2'b00) ? {4{wreg_data_i[7:0]}} :
                   (funct3_i[1:0] == 2'b01) ? {2{wreg_data_i[15:0]}} : wreg_data_i;

  load_ext u_ext (.rdata(bus_rdata_i), .addr(off_q), .funct3(f3_q), .data(ext));

  always_ff @(posedge clk)
    state <= rst ? MEM_IDLE : state_n;

  always_comb
    state_n = accept ? MEM_BUSY : (ack || tout) ? MEM_IDLE : state;

  always_comb begin
    stall_o   = accept || ((state == MEM_BUSY) && !bus_ack_i && !tout);
    bus_req_o = state == MEM_BUSY;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0; f3_q <= '0; off_q <= '0; wen_q <= 1'b0; wa_q <= '0;
      bus_we_o <= 1'b0; bus_addr_o <= '0; bus_wstrb_o <= '0; bus_wdata_o <= '0;
      wb_valid_o <= 1'b0; wreg_en_o <= 1'b0; wreg_addr_o <= '0; wreg_data_o <= '0;
      misalign_o <= 1'b0; bus_err_o <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      misalign_o <= 1'b0;
      bus_err_o  <= 1'b0;
      if (idle_in && !accept) begin
        wb_valid_o  <= 1'b1;
        misalign_o  <= mem_en;
        wreg_en_o   <= wreg_en_i && !mem_en;
        wreg_addr_o <= wreg_addr_i;
        wreg_data_o <= wreg_data_i;
      end else if (accept) begin
        cnt         <= '0;
        f3_q        <= funct3_i;
        off_q       <= mem_addr_i[1:0];
        wen_q       <= wreg_en_i && !wmem_en_i;
        wa_q        <= wreg_addr_i;
        bus_we_o    <= wmem_en_i;
        bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
        bus_wstrb_o <= wmem_en_i ? strb : 4'b0000;
        bus_wdata_o <= wmem_en_i ? wdat : 32'b0;
      end else if (ack || tout) begin
        wb_valid_o  <= 1'b1;
        bus_err_o   <= tout;
        wreg_en_o   <= ack && wen_q;
        wreg_addr_o <= wa_q;
        wreg_data_o <= (ack && !bus_we_o) ? ext : 32'b0;
      end else if (state == MEM_BUSY) begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule
